// File: rtl/bcd_7seg_pkg.sv
// Shared constants for the BCD seven-segment display driver.
//   NIB_W         : width of one BCD digit
//   SEG_0..SEG_9  : active-low segment codes, bit order {g,f,e,d,c,b,a}
//   SEG_DASH      : shown for non-decimal nibbles 10..15
//   SEG_BLANK     : all segments off
//   slot_state_t  : phase within one digit slot (derived from the prescaler)
package bcd_7seg_pkg;

  localparam int NIB_W = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    GUARD_S = 1'b0,
    ON_S    = 1'b1
  } slot_state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational nibble-to-segment decoder.
//   nib_i : BCD nibble (10..15 produce a dash)
//   seg_o : active-low segments {g,f,e,d,c,b,a}
module bcd_to_7seg
  import bcd_7seg_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [6:0]       seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nib_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_driver.sv
// Multiplexed seven-segment driver for a packed BCD value.
// A value is latched on each rising edge of the converter ready level and
// scanned across DIGITS anodes, DIV cycles per digit, the first GUARD cycles
// of every slot dark to avoid ghosting.
//   clk      : clock
//   rst      : synchronous active-high reset
//   bcd_i    : packed BCD value, digit 0 in bits [3:0]
//   rdy_i    : converter ready level; rising edge marks bcd_i valid
//   lz_en_i  : 1 enables leading-zero blanking
//   seg_o    : active-low segments {g,f,e,d,c,b,a}, registered
//   an_o     : active-low anodes, at most one low, registered
//   upd_o    : one-cycle pulse after a new value has been latched
module bcd_7seg_driver
  import bcd_7seg_pkg::*;
#(
  parameter int DIGITS = 5,
  parameter int DIV    = 50000,
  parameter int GUARD  = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NIB_W*DIGITS-1:0] bcd_i,
  input  logic                    rdy_i,
  input  logic                    lz_en_i,
  output logic [6:0]              seg_o,
  output logic [DIGITS-1:0]       an_o,
  output logic                    upd_o
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] GUARD_C  = PRE_W'(GUARD);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);

  logic                    rdy_q;
  logic [NIB_W*DIGITS-1:0] val_r;
  logic [PRE_W-1:0]        pre_r;
  logic [DIG_W-1:0]        dig_r;
  logic [6:0]              pat_r;
  logic                    blk_r;
  logic [6:0]              r_seg;
  logic [DIGITS-1:0]       r_an;
  logic                    r_upd;

  logic                    w_rise;
  logic [NIB_W-1:0]        w_nib_arr [DIGITS];
  logic [DIGITS-1:0]       w_lz_blank;
  logic [NIB_W-1:0]        w_nib;
  logic [6:0]              w_dec_seg;
  logic                    w_blank;
  slot_state_t             w_state;
  logic [DIGITS-1:0]       w_an_next;
  logic [6:0]              w_seg_next;

  assign w_rise = rdy_i & ~rdy_q;

  // Digit k is a leading zero when it and every higher digit are zero.
  // Each digit looks at its own constant slice, so there is no
  // combinational chain between neighbouring bits.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
      assign w_nib_arr[gi]  = val_r[gi*NIB_W +: NIB_W];
      if (gi == 0) begin : g_lsd
        assign w_lz_blank[gi] = 1'b0;
      end else begin : g_hsd
        assign w_lz_blank[gi] = ~|val_r[NIB_W*DIGITS-1 : gi*NIB_W];
      end
    end
  endgenerate

  assign w_nib   = w_nib_arr[dig_r];
  assign w_blank = lz_en_i & w_lz_blank[dig_r];

  bcd_to_7seg u_dec (
    .nib_i (w_nib),
    .seg_o (w_dec_seg)
  );

  // Slot phase comes straight from the prescaler; only the outputs are
  // registered, which gives the one-cycle output latency.
  always_comb begin
    w_state    = (pre_r < GUARD_C) ? GUARD_S : ON_S;
    w_an_next  = '1;
    w_seg_next = SEG_BLANK;
    if (w_state == ON_S && !blk_r) begin
      w_an_next  = ~(DIGITS'(1) << dig_r);
      w_seg_next = pat_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q <= 1'b0;
      val_r <= '0;
      pre_r <= '0;
      dig_r <= '0;
      pat_r <= SEG_BLANK;
      blk_r <= 1'b1;
      r_seg <= SEG_BLANK;
      r_an  <= '1;
      r_upd <= 1'b0;
    end else begin
      rdy_q <= rdy_i;
      r_upd <= w_rise;
      if (w_rise) begin
        val_r <= bcd_i;
      end

      if (pre_r == PRE_LAST) begin
        pre_r <= '0;
        dig_r <= (dig_r == DIG_LAST) ? '0 : dig_r + 1'b1;
      end else begin
        pre_r <= pre_r + 1'b1;
      end

      // Pattern and blanking are frozen at slot start so a value update
      // never tears the digit currently on display.
      if (pre_r == '0) begin
        blk_r <= w_blank;
        pat_r <= w_blank ? SEG_BLANK : w_dec_seg;
      end

      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign seg_o = r_seg;
  assign an_o  = r_an;
  assign upd_o = r_upd;

endmodule

// File: tb/tb_bcd_7seg_driver.sv
module tb_bcd_7seg_driver;

  localparam int DIGITS = 5;
  localparam int DIV    = 8;
  localparam int GUARD  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [4*DIGITS-1:0] bcd_i = '0;
  logic              rdy_i = 1'b0;
  logic              lz_en_i = 1'b1;
  logic [6:0]        seg_o;
  logic [DIGITS-1:0] an_o;
  logic              upd_o;

  bcd_7seg_driver #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk     (clk),
    .rst     (rst),
    .bcd_i   (bcd_i),
    .rdy_i   (rdy_i),
    .lz_en_i (lz_en_i),
    .seg_o   (seg_o),
    .an_o    (an_o),
    .upd_o   (upd_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   upd_cnt = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [4:0] an, input logic [6:0] seg);
    exp_t e;
    e.an  = an;
    e.seg = seg;
    exp_q.push_back(e);
  endtask

  // Watches every lit period: compares its anode/segments against the
  // scoreboard, checks it stays stable, lasts DIV-GUARD cycles and is
  // preceded by a dark gap of GUARD cycles (plus whole blanked slots).
  task automatic monitor();
    logic [4:0] prev_an = 5'h1f;
    logic [4:0] lit_an  = 5'h1f;
    logic [6:0] lit_seg = 7'h7f;
    int         lit_len = 0;
    int         gap = 0;
    bit         gap_valid = 1'b0;
    bit         prev_upd = 1'b0;
    bit         cur_lit, prev_lit;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_an   = 5'h1f;
        gap       = 0;
        gap_valid = 1'b0;
        lit_len   = 0;
        prev_upd  = 1'b0;
      end else begin
        cur_lit  = (an_o != 5'h1f);
        prev_lit = (prev_an != 5'h1f);
        if (upd_o) begin
          upd_cnt++;
          chk("upd_width", int'(prev_upd), 0);
        end
        if (cur_lit && !prev_lit) begin
          lit_an  = an_o;
          lit_seg = seg_o;
          lit_len = 1;
          if (chk_en) begin
            if (gap_valid) chk("guard_gap", gap % DIV, GUARD);
            if (exp_q.size() == 0) begin
              chk("unexpected_lit", int'(an_o), 5'h1f);
            end else begin
              e = exp_q.pop_front();
              chk("lit_an", int'(an_o), int'(e.an));
              chk("lit_seg", int'(seg_o), int'(e.seg));
            end
          end
        end else if (cur_lit) begin
          lit_len++;
          if (chk_en) begin
            chk("lit_an_stable", int'(an_o), int'(lit_an));
            chk("lit_seg_stable", int'(seg_o), int'(lit_seg));
          end
        end else begin
          if (prev_lit) begin
            if (chk_en) chk("on_len", lit_len, DIV - GUARD);
            gap       = 1;
            gap_valid = 1'b1;
          end else begin
            gap++;
          end
          chk("dark_seg", int'(seg_o), 7'h7f);
        end
        prev_an  = an_o;
        prev_upd = upd_o;
      end
    end
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("scoreboard_drain", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic scan();
    chk_en = 1'b1;
    wait_empty(120);
    chk_en = 1'b0;
  endtask

  // Returns just after the digit-0 slot ends; every slot from here on was
  // started after any stimulus issued before the call.
  task automatic sync_d0();
    int n = 0;
    @(negedge clk);
    while (an_o != 5'h1e && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (an_o != 5'h1e) chk("sync_d0_on", int'(an_o), 5'h1e);
    n = 0;
    while (an_o == 5'h1e && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (an_o == 5'h1e) chk("sync_d0_off", int'(an_o), 5'h1f);
  endtask

  task automatic rise(input logic [19:0] v);
    @(negedge clk);
    bcd_i = v;
    rdy_i = 1'b1;
    @(negedge clk);
    chk("upd_pulse", int'(upd_o), 1);
    @(negedge clk);
    chk("upd_drop", int'(upd_o), 0);
    rdy_i = 1'b0;
  endtask

  task automatic stimulus();
    int  n;
    bit  found;
    logic [4:0] prev;

    // Reset: dark display, no update pulse.
    repeat (3) begin
      @(negedge clk);
      chk("rst_an", int'(an_o), 5'h1f);
      chk("rst_seg", int'(seg_o), 7'h7f);
      chk("rst_upd", int'(upd_o), 0);
    end
    // Release with value 0: only digit 0 lights, showing 0.
    push(5'h1e, 7'h40);
    chk_en = 1'b1;
    rst = 1'b0;
    wait_empty(60);
    push(5'h1e, 7'h40);
    wait_empty(60);
    chk_en = 1'b0;

    // 0x01234 with blanking: digit 4 stays dark.
    rise(20'h01234);
    sync_d0();
    push(5'h1d, 7'h30); push(5'h1b, 7'h24); push(5'h17, 7'h79); push(5'h1e, 7'h19);
    scan();

    // All zero, blanking on then off.
    upd_cnt = 0;
    rise(20'h00000);
    sync_d0();
    push(5'h1e, 7'h40);
    scan();
    lz_en_i = 1'b0;
    sync_d0();
    push(5'h1d, 7'h40); push(5'h1b, 7'h40); push(5'h17, 7'h40); push(5'h0f, 7'h40);
    push(5'h1e, 7'h40);
    scan();
    chk("upd_count_zero", upd_cnt, 1);
    lz_en_i = 1'b1;

    // Non-decimal nibble in digit 2 shows a dash; zero below it is kept.
    rise(20'h00A00);
    sync_d0();
    push(5'h1d, 7'h40); push(5'h1b, 7'h3f); push(5'h1e, 7'h40);
    scan();

    // rdy held high while bcd_i keeps changing: one latch only.
    upd_cnt = 0;
    @(negedge clk);
    bcd_i = 20'h56789;
    rdy_i = 1'b1;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          bcd_i = 20'(i * 4099 + 20'h31415);
        end
        rdy_i = 1'b0;
      end
      begin
        sync_d0();
        push(5'h1d, 7'h00); push(5'h1b, 7'h78); push(5'h17, 7'h02); push(5'h0f, 7'h12);
        push(5'h1e, 7'h10);
        scan();
      end
    join
    chk("upd_count_hold", upd_cnt, 1);

    // New value arrives at pre_r=3 of the digit-2 slot: that slot keeps
    // its old pattern, the new value shows from the digit-3 slot on.
    found = 1'b0;
    prev  = an_o;
    n     = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (an_o == 5'h1b && prev != 5'h1b) found = 1'b1;
      prev = an_o;
    end
    if (!found) chk("find_d2_start", int'(an_o), 5'h1b);
    bcd_i = 20'h43210;
    rdy_i = 1'b1;
    push(5'h17, 7'h30); push(5'h0f, 7'h19); push(5'h1e, 7'h40); push(5'h1d, 7'h79);
    push(5'h1b, 7'h24);
    @(negedge clk);
    scan();
    rdy_i = 1'b0;

    // Reset mid-scan with rdy high: scan restarts at digit 0 (old pattern
    // computed before the latch), value latched on the first cycle.
    @(negedge clk);
    rst   = 1'b1;
    bcd_i = 20'h00007;
    rdy_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst2_an", int'(an_o), 5'h1f);
      chk("rst2_upd", int'(upd_o), 0);
    end
    push(5'h1e, 7'h40); push(5'h1e, 7'h78);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("upd_release", int'(upd_o), 1);
    wait_empty(100);
    chk_en = 1'b0;
    rdy_i = 1'b0;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_7seg_driver.md
BCD_7SEG_DRIVER -- requirements
Module: bcd_7seg_driver

Interface
REQ-001 Parameter DIGITS, default 5: number of BCD digits and anodes, range 1..8.
REQ-002 Parameter DIV, default 50000: clock cycles per digit slot, minimum GUARD+2.
REQ-003 Parameter GUARD, default 500: cycles at the start of each slot with all anodes off, minimum 1.
REQ-004 Port clk, input, 1: single clock, rising edge; the only clock.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port bcd_i, input, 4*DIGITS: packed BCD value, digit k at bits [4k+3:4k], digit 0 least significant; driven by the binary-to-BCD converter data_o.
REQ-007 Port rdy_i, input, 1: converter ready level; a rising edge marks bcd_i valid.
REQ-008 Port lz_en_i, input, 1: 1 enables leading-zero blanking.
REQ-009 Port seg_o, output, 7: segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 Port an_o, output, DIGITS: digit anodes, active-low, at most one low, registered.
REQ-011 Port upd_o, output, 1: one-cycle pulse on the cycle after a new value is latched.

Function
REQ-012 Rise detection: rdy_q registers rdy_i; a rise is rdy_i=1 and rdy_q=0 in the same cycle.
REQ-013 On a rise, bcd_i is captured into val_r on that clock edge; upd_o is 1 on the following cycle only.
REQ-014 rdy_i held high latches once; bcd_i changes while rdy_i stays high are ignored.
REQ-015 Prescaler pre_r counts 0..DIV-1 and wraps; at wrap, digit index dig_r advances 0,1,..,DIGITS-1 and wraps to 0.
REQ-016 Per-slot FSM states are GUARD_S (pre_r < GUARD) and ON_S (pre_r >= GUARD), derived from pre_r with no separate state register.
REQ-017 In GUARD_S: an_o all ones, seg_o = 7'b1111111.
REQ-018 At slot start (pre_r=0), pattern pat_r is computed from val_r digit dig_r and held for the whole slot; a val_r update mid-slot appears from the next slot.
REQ-019 In ON_S: an_o has bit dig_r low and all other bits high; seg_o = pat_r.
REQ-020 Decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 Nibbles 10..15 decode to a dash: seg_o = 0111111.
REQ-022 Leading-zero blanking with lz_en_i=1: digit k>0 is blanked when it and all higher digits equal 0; a blanked digit keeps its anode high and seg_o = 1111111 during ON_S; digit 0 is never blanked.
REQ-023 lz_en_i is sampled at slot start together with pat_r.
REQ-024 Output latency: an_o and seg_o reflect pre_r and dig_r one cycle late, since both outputs are registered.

Reset
REQ-025 While rst=1: an_o all ones, seg_o = 1111111, upd_o = 0, val_r = 0, pat_r = blank, pre_r = 0, dig_r = 0, rdy_q = 0.
REQ-026 Reset mid-slot aborts the scan; after release, scanning restarts at digit 0 in GUARD_S.
REQ-027 rdy_i high at reset release is treated as a rise and latched on the first cycle after release.

Structure
REQ-028 Package bcd_7seg_pkg holds the segment code constants (digits 0..9, DASH, BLANK) and the nibble width constant.
REQ-029 Sub-module bcd_to_7seg is the combinational nibble-to-segment decoder, instantiated once and fed by the digit selected at slot start.
REQ-030 No other sub-modules; the prescaler, digit counter, edge detector and blanking logic live in the top module.

Verification (DIGITS=5, DIV=8, GUARD=2)
REQ-031 Hold rst for 3 cycles, then release with rdy_i=0 -> during reset an_o=11111 and seg_o=1111111; after release, digit 0 shows 1000000 with an_o=11110 in ON_S.
REQ-032 Apply bcd_i=0x01234, rdy_i pulse, lz_en_i=1 -> slots show digit0=0011001, digit1=0110000, digit2=0100100, digit3=1111001, digit4 anode never low; upd_o high exactly 1 cycle.
REQ-033 Apply bcd_i=0x00000, rdy_i rise, lz_en_i=1 -> only an_o=11110 ever goes low, showing 1000000; with lz_en_i=0, all five digits show 1000000.
REQ-034 Apply nibble 0xA in digit 2 -> digit 2 slot shows 0111111.
REQ-035 Hold rdy_i high for 100 cycles while bcd_i changes every cycle -> only the value at the rising edge is displayed; upd_o pulses once.
REQ-036 Raise rdy_i at pre_r=3 of a slot -> the current slot keeps its old pattern and the new value appears from the next slot; a GUARD gap of 2 cycles with all anodes high precedes every ON_S.
